// File: rtl/mpsoc3d_ahb4_pkg.sv
// Shared AHB-Lite encodings for the external-port arbiter and its bench.
package mpsoc3d_ahb4_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

endpackage

// File: rtl/mpsoc3d_ahb4_ext_arbiter_if.sv
// Bundle of the N host-side AHB-Lite masters plus the single external slave port.
// slave modport = arbiter view, master modport = hosts/system view.
interface mpsoc3d_ahb4_ext_arbiter_if
    import mpsoc3d_ahb4_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int PLEN        = 32,
    parameter int XLEN        = 32
);
    // host-side masters
    logic [NUM_MASTERS-1:0]           m_hsel;
    logic [NUM_MASTERS-1:0][PLEN-1:0] m_haddr;
    logic [NUM_MASTERS-1:0][XLEN-1:0] m_hwdata;
    logic [NUM_MASTERS-1:0]           m_hwrite;
    logic [NUM_MASTERS-1:0][2:0]      m_hsize;
    logic [NUM_MASTERS-1:0][2:0]      m_hburst;
    logic [NUM_MASTERS-1:0][3:0]      m_hprot;
    logic [NUM_MASTERS-1:0][1:0]      m_htrans;
    logic [NUM_MASTERS-1:0]           m_hmastlock;
    logic [NUM_MASTERS-1:0][XLEN-1:0] m_hrdata;
    logic [NUM_MASTERS-1:0]           m_hready;
    logic [NUM_MASTERS-1:0]           m_hresp;

    // external slave port
    logic            ext_hsel;
    logic [PLEN-1:0] ext_haddr;
    logic [XLEN-1:0] ext_hwdata;
    logic            ext_hwrite;
    logic [2:0]      ext_hsize;
    logic [2:0]      ext_hburst;
    logic [3:0]      ext_hprot;
    logic [1:0]      ext_htrans;
    logic            ext_hmastlock;
    logic [XLEN-1:0] ext_hrdata;
    logic            ext_hready;
    logic            ext_hresp;

    modport slave (
        input  m_hsel, m_haddr, m_hwdata, m_hwrite, m_hsize, m_hburst, m_hprot,
               m_htrans, m_hmastlock, ext_hrdata, ext_hready, ext_hresp,
        output m_hrdata, m_hready, m_hresp, ext_hsel, ext_haddr, ext_hwdata,
               ext_hwrite, ext_hsize, ext_hburst, ext_hprot, ext_htrans, ext_hmastlock
    );

    modport master (
        output m_hsel, m_haddr, m_hwdata, m_hwrite, m_hsize, m_hburst, m_hprot,
               m_htrans, m_hmastlock, ext_hrdata, ext_hready, ext_hresp,
        input  m_hrdata, m_hready, m_hresp, ext_hsel, ext_haddr, ext_hwdata,
               ext_hwrite, ext_hsize, ext_hburst, ext_hprot, ext_htrans, ext_hmastlock
    );

endinterface

// File: rtl/mpsoc3d_rr_picker.sv
// Round-robin picker: first set request strictly after ptr, wrapping modulo N.
// Purely combinational; onehot is all-zero when nothing is requested.
module mpsoc3d_rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx
);
    localparam int W = $clog2(N);

    logic         found;
    logic [W-1:0] j;

    // Scan ptr+1 .. ptr+N; the first hit wins, ptr itself is considered last.
    always_comb begin
        onehot = '0;
        idx    = ptr;
        found  = 1'b0;
        j      = '0;
        for (int k = 1; k <= N; k++) begin
            j = W'((int'(ptr) + k) % N);
            if (!found && req[j]) begin
                found     = 1'b1;
                idx       = j;
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mpsoc3d_ahb4_ext_arbiter.sv
// Round-robin AHB-Lite arbiter sharing the external slave port between NUM_MASTERS
// hosts. The address-phase owner is forwarded combinationally; non-owners are stalled
// with hready=0. Ownership moves only when the owner is idle, unlocked and the slave
// is ready, so bursts and locked sequences are never split.
module mpsoc3d_ahb4_ext_arbiter
    import mpsoc3d_ahb4_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int PLEN        = 32,
    parameter int XLEN        = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    mpsoc3d_ahb4_ext_arbiter_if.slave      bus,
    output logic [$clog2(NUM_MASTERS)-1:0] grant
);
    localparam int               GW  = $clog2(NUM_MASTERS);
    localparam [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

    logic [GW-1:0]          grant_q;
    logic [GW-1:0]          dph_own_q;
    logic                   dph_vld_q;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] others;
    logic [NUM_MASTERS-1:0] pick_oh;
    logic [GW-1:0]          pick_idx;
    logic                   own_idle;
    logic                   do_switch;

    // A master asks for the bus only by starting a new transfer.
    always_comb begin
        req = '0;
        for (int m = 0; m < NUM_MASTERS; m++)
            req[m] = bus.m_hsel[m] && (bus.m_htrans[m] == HTRANS_NONSEQ);
    end

    assign others = req & ~(ONE << grant_q);

    mpsoc3d_rr_picker #(.N(NUM_MASTERS)) u_picker (
        .req    (others),
        .ptr    (grant_q),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    // Switch only at a transfer boundary of an unlocked owner; BUSY/SEQ keep the bus.
    assign own_idle  = (bus.m_htrans[grant_q] == HTRANS_IDLE) || !bus.m_hsel[grant_q];
    assign do_switch = bus.ext_hready && own_idle && !bus.m_hmastlock[grant_q] && |pick_oh;

    // Grant pointer and data-phase tracking advance only when the slave accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q   <= '0;
            dph_vld_q <= 1'b0;
            dph_own_q <= '0;
        end else if (bus.ext_hready) begin
            dph_vld_q <= bus.m_hsel[grant_q] && (bus.m_htrans[grant_q] != HTRANS_IDLE);
            dph_own_q <= grant_q;
            if (do_switch)
                grant_q <= pick_idx;
        end
    end

    // Address phase: owner's fields straight through; data phase: data-phase owner's wdata.
    assign bus.ext_hsel      = bus.m_hsel[grant_q];
    assign bus.ext_haddr     = bus.m_haddr[grant_q];
    assign bus.ext_hwrite    = bus.m_hwrite[grant_q];
    assign bus.ext_hsize     = bus.m_hsize[grant_q];
    assign bus.ext_hburst    = bus.m_hburst[grant_q];
    assign bus.ext_hprot     = bus.m_hprot[grant_q];
    assign bus.ext_htrans    = bus.m_htrans[grant_q];
    assign bus.ext_hmastlock = bus.m_hmastlock[grant_q];
    assign bus.ext_hwdata    = bus.m_hwdata[dph_own_q];

    // Per-master response: the address owner and the data-phase owner see the slave,
    // everybody else is held in wait states; error response only goes to the data owner.
    for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_resp
        logic is_dph;
        assign is_dph          = dph_vld_q && (dph_own_q == GW'(m));
        assign bus.m_hready[m] = bus.ext_hready && ((grant_q == GW'(m)) || is_dph);
        assign bus.m_hresp[m]  = is_dph ? bus.ext_hresp : HRESP_OKAY;
        assign bus.m_hrdata[m] = bus.ext_hrdata;
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_mpsoc3d_ahb4_ext_arbiter.sv
// Directed bench for the external-port arbiter. Each stimulus cycle pushes its
// hand-computed expectation into a queue; a negedge monitor pops and compares.
module tb_mpsoc3d_ahb4_ext_arbiter;
    import mpsoc3d_ahb4_pkg::*;

    localparam logic [1:0] IDL = HTRANS_IDLE;
    localparam logic [1:0] NSQ = HTRANS_NONSEQ;
    localparam logic [1:0] SQ  = HTRANS_SEQ;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] grant;

    mpsoc3d_ahb4_ext_arbiter_if #(.NUM_MASTERS(4), .PLEN(32), .XLEN(32)) bus ();

    mpsoc3d_ahb4_ext_arbiter #(.NUM_MASTERS(4), .PLEN(32), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .grant (grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        int          g;
        logic [1:0]  tr;
        logic [31:0] ad;
        logic [3:0]  rdy;
        logic [3:0]  rsp;
        int          own;   // expected data-phase owner for hwdata, -1 = don't care
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   nstep  = 0;

    task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, f, act, expv);
        end
    endtask

    // Monitor: compare every pending expectation against the settled outputs.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk(e.nm, "grant",  32'(grant),          32'(e.g));
            chk(e.nm, "htrans", 32'(bus.ext_htrans), 32'(e.tr));
            chk(e.nm, "haddr",  bus.ext_haddr,       e.ad);
            chk(e.nm, "hready", 32'(bus.m_hready),   32'(e.rdy));
            chk(e.nm, "hresp",  32'(bus.m_hresp),    32'(e.rsp));
            chk(e.nm, "hwrite", 32'(bus.ext_hwrite), (e.g != 1) ? 32'd1 : 32'd0);
            chk(e.nm, "hrdata", bus.m_hrdata[nstep % 4], bus.ext_hrdata);
            if (e.own >= 0)
                chk(e.nm, "hwdata", bus.ext_hwdata, 32'hDA7A_0000 + e.own);
        end
    end

    task automatic drv(input int m, input logic sel, input logic [1:0] tr,
                       input logic [31:0] a, input logic lk);
        bus.m_hsel[m[1:0]]      = sel;
        bus.m_htrans[m[1:0]]    = tr;
        bus.m_haddr[m[1:0]]     = a;
        bus.m_hmastlock[m[1:0]] = lk;
    endtask

    task automatic step(input string nm, input int g, input logic [1:0] tr, input logic [31:0] ad,
                        input logic [3:0] rdy, input logic [3:0] rsp, input int own);
        exp_t e;
        nstep++;
        bus.ext_hrdata = 32'hCAFE_0000 + nstep;
        e.nm = nm; e.g = g; e.tr = tr; e.ad = ad; e.rdy = rdy; e.rsp = rsp; e.own = own;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.ext_hready = 1'b1;
        bus.ext_hresp  = HRESP_OKAY;
        bus.ext_hrdata = '0;
        for (int m = 0; m < 4; m++) begin
            drv(m, 1'b0, IDL, 32'h0, 1'b0);
            bus.m_hwdata[m[1:0]] = 32'hDA7A_0000 + m;
            bus.m_hwrite[m[1:0]] = (m != 1);
            bus.m_hsize[m[1:0]]  = 3'b010;
            bus.m_hburst[m[1:0]] = HBURST_SINGLE;
            bus.m_hprot[m[1:0]]  = 4'b0011;
        end
        @(posedge clk);
        #1;
        step("rst", 0, IDL, 32'h0, 4'b0001, 4'b0, -1);

        // 1: single write from M0, slave inserts one wait state in its data phase
        rst_n = 1'b1;
        drv(0, 1'b1, NSQ, 32'h100, 1'b0);
        step("t1_nseq", 0, NSQ, 32'h100, 4'b0001, 4'b0, -1);
        drv(0, 1'b0, IDL, 32'h100, 1'b0); bus.ext_hready = 1'b0;
        step("t1_wait", 0, IDL, 32'h100, 4'b0000, 4'b0, 0);
        bus.ext_hready = 1'b1;
        step("t1_done", 0, IDL, 32'h100, 4'b0001, 4'b0, 0);

        // 2: M0 INCR4 while M1 waits; hand-over only after M0 idles
        drv(0, 1'b1, NSQ, 32'h200, 1'b0); bus.m_hburst[0] = HBURST_INCR4;
        drv(1, 1'b1, NSQ, 32'h1000, 1'b0);
        step("t2_b0", 0, NSQ, 32'h200, 4'b0001, 4'b0, -1);
        drv(0, 1'b1, SQ, 32'h204, 1'b0);
        step("t2_b1", 0, SQ, 32'h204, 4'b0001, 4'b0, 0);
        drv(0, 1'b1, SQ, 32'h208, 1'b0);
        step("t2_b2", 0, SQ, 32'h208, 4'b0001, 4'b0, 0);
        drv(0, 1'b1, SQ, 32'h20C, 1'b0);
        step("t2_b3", 0, SQ, 32'h20C, 4'b0001, 4'b0, 0);
        drv(0, 1'b0, IDL, 32'h20C, 1'b0); bus.m_hburst[0] = HBURST_SINGLE;
        step("t2_sw", 0, IDL, 32'h20C, 4'b0001, 4'b0, 0);
        step("t2_m1", 1, NSQ, 32'h1000, 4'b0010, 4'b0, -1);
        drv(1, 1'b0, IDL, 32'h1000, 1'b0);
        step("t2_m1d", 1, IDL, 32'h1000, 4'b0010, 4'b0, 1);

        // 3: M0, M1, M3 contend -> 0, 1, 3, 0 (M2 skipped)
        drv(0, 1'b1, NSQ, 32'h300, 1'b0);
        step("t3_park", 1, IDL, 32'h1000, 4'b0010, 4'b0, -1);
        drv(1, 1'b1, NSQ, 32'h1100, 1'b0);
        drv(3, 1'b1, NSQ, 32'h3300, 1'b0);
        step("t3_g0", 0, NSQ, 32'h300, 4'b0001, 4'b0, -1);
        drv(0, 1'b0, IDL, 32'h300, 1'b0);
        step("t3_sw1", 0, IDL, 32'h300, 4'b0001, 4'b0, 0);
        drv(0, 1'b1, NSQ, 32'h304, 1'b0);
        step("t3_g1", 1, NSQ, 32'h1100, 4'b0010, 4'b0, -1);
        drv(1, 1'b0, IDL, 32'h1100, 1'b0);
        step("t3_sw3", 1, IDL, 32'h1100, 4'b0010, 4'b0, 1);
        step("t3_g3", 3, NSQ, 32'h3300, 4'b1000, 4'b0, -1);
        drv(3, 1'b0, IDL, 32'h3300, 1'b0);
        step("t3_sw0", 3, IDL, 32'h3300, 4'b1000, 4'b0, 3);
        step("t3_g0b", 0, NSQ, 32'h304, 4'b0001, 4'b0, -1);
        drv(0, 1'b0, IDL, 32'h304, 1'b0);
        step("t3_park0", 0, IDL, 32'h304, 4'b0001, 4'b0, 0);

        // 4: M2 locked sequence with an IDLE gap keeps the bus against M0
        drv(2, 1'b1, NSQ, 32'h2200, 1'b1);
        step("t4_req2", 0, IDL, 32'h304, 4'b0001, 4'b0, -1);
        drv(0, 1'b1, NSQ, 32'h400, 1'b0);
        step("t4_l0", 2, NSQ, 32'h2200, 4'b0100, 4'b0, -1);
        drv(2, 1'b1, IDL, 32'h2200, 1'b1);
        step("t4_lidle", 2, IDL, 32'h2200, 4'b0100, 4'b0, 2);
        drv(2, 1'b1, NSQ, 32'h2204, 1'b1);
        step("t4_l1", 2, NSQ, 32'h2204, 4'b0100, 4'b0, -1);
        drv(2, 1'b0, IDL, 32'h2204, 1'b0);
        step("t4_unl", 2, IDL, 32'h2204, 4'b0100, 4'b0, 2);
        step("t4_g0", 0, NSQ, 32'h400, 4'b0001, 4'b0, -1);
        drv(0, 1'b0, IDL, 32'h400, 1'b0);
        step("t4_g0d", 0, IDL, 32'h400, 4'b0001, 4'b0, 0);

        // 5: two-cycle ERROR on an M1 read, M0 waiting
        drv(1, 1'b1, NSQ, 32'h1200, 1'b0);
        step("t5_req1", 0, IDL, 32'h400, 4'b0001, 4'b0, -1);
        drv(0, 1'b1, NSQ, 32'h500, 1'b0);
        step("t5_a", 1, NSQ, 32'h1200, 4'b0010, 4'b0, -1);
        drv(1, 1'b0, IDL, 32'h1200, 1'b0);
        bus.ext_hready = 1'b0; bus.ext_hresp = HRESP_ERROR;
        step("t5_err1", 1, IDL, 32'h1200, 4'b0000, 4'b0010, 1);
        bus.ext_hready = 1'b1;
        step("t5_err2", 1, IDL, 32'h1200, 4'b0010, 4'b0010, 1);
        bus.ext_hresp = HRESP_OKAY;
        step("t5_g0", 0, NSQ, 32'h500, 4'b0001, 4'b0, -1);
        drv(0, 1'b0, IDL, 32'h500, 1'b0);
        step("t5_g0d", 0, IDL, 32'h500, 4'b0001, 4'b0, 0);

        // 6: async reset during the second beat of an M3 burst
        drv(3, 1'b1, NSQ, 32'h3000, 1'b0); bus.m_hburst[3] = HBURST_INCR4;
        step("t6_req3", 0, IDL, 32'h500, 4'b0001, 4'b0, -1);
        drv(0, 1'b1, NSQ, 32'h600, 1'b0);
        step("t6_b0", 3, NSQ, 32'h3000, 4'b1000, 4'b0, -1);
        drv(3, 1'b1, SQ, 32'h3004, 1'b0);
        step("t6_b1", 3, SQ, 32'h3004, 4'b1000, 4'b0, 3);
        drv(3, 1'b1, SQ, 32'h3008, 1'b0);
        rst_n = 1'b0;
        step("t6_rst", 0, NSQ, 32'h600, 4'b0001, 4'b0, -1);
        drv(3, 1'b0, IDL, 32'h3008, 1'b0);
        drv(0, 1'b0, IDL, 32'h600, 1'b0);
        rst_n = 1'b1;
        step("t6_post", 0, IDL, 32'h600, 4'b0001, 4'b0, -1);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
